// File: rtl/font_rom_arbiter.sv
// Shares one synchronous font ROM between a latency-critical port A and a secondary port B.
// Port A has fixed priority; a bounded-wait counter guarantees port B a grant every MAX_WAIT+1 cycles.
module font_rom_arbiter #(
   parameter int unsigned ADDR_SIZE = 7,
   parameter int unsigned FNT_W     = 4,
   parameter int unsigned ROM_LAT   = 1,
   parameter int unsigned MAX_WAIT  = 8
) (
   input  logic                 clk,
   input  logic                 rst,
   output logic [ADDR_SIZE-1:0] rom_addr,
   input  logic [FNT_W-1:0]     rom_q,
   input  logic                 a_req,
   input  logic [ADDR_SIZE-1:0] a_addr,
   output logic                 a_gnt,
   output logic                 a_valid,
   output logic [FNT_W-1:0]     a_data,
   input  logic                 b_req,
   input  logic [ADDR_SIZE-1:0] b_addr,
   output logic                 b_gnt,
   output logic                 b_valid,
   output logic [FNT_W-1:0]     b_data
);

   localparam int unsigned WAIT_W = 8;
   localparam int unsigned DEPTH  = ROM_LAT + 1;

   logic [WAIT_W-1:0] b_wait;
   logic [WAIT_W-1:0] b_wait_nxt_c;
   logic              b_force_c;
   logic              accept_c;
   logic [DEPTH-1:0]  pipe_vld;
   logic [DEPTH-1:0]  pipe_port;
   logic              tail_a_c;
   logic              tail_b_c;

   // Grant decision and starvation counter next-state
   always_comb begin
      b_force_c    = (b_wait == WAIT_W'(MAX_WAIT));
      a_gnt        = !rst && a_req && !(b_req && b_force_c);
      b_gnt        = !rst && b_req && !a_gnt;
      accept_c     = a_gnt || b_gnt;
      b_wait_nxt_c = b_wait;
      if (b_gnt || !b_req) begin
         b_wait_nxt_c = '0;
      end else if (!b_force_c) begin
         b_wait_nxt_c = b_wait + WAIT_W'(1);
      end
   end

   // Pipeline tail lines up with rom_q; port bit 1 marks a port-B read
   always_comb begin
      tail_a_c = pipe_vld[DEPTH-1] && !pipe_port[DEPTH-1];
      tail_b_c = pipe_vld[DEPTH-1] &&  pipe_port[DEPTH-1];
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         b_wait    <= '0;
         rom_addr  <= '0;
         pipe_vld  <= '0;
         pipe_port <= '0;
         a_valid   <= 1'b0;
         b_valid   <= 1'b0;
         a_data    <= '0;
         b_data    <= '0;
      end else begin
         b_wait    <= b_wait_nxt_c;
         if (accept_c) begin
            rom_addr <= a_gnt ? a_addr : b_addr;
         end
         pipe_vld  <= {pipe_vld[DEPTH-2:0], accept_c};
         pipe_port <= {pipe_port[DEPTH-2:0], b_gnt};
         a_valid   <= tail_a_c;
         b_valid   <= tail_b_c;
         if (tail_a_c) begin
            a_data <= rom_q;
         end
         if (tail_b_c) begin
            b_data <= rom_q;
         end
      end
   end

endmodule

// File: tb/tb_font_rom_arbiter.sv
// Directed self-checking bench for font_rom_arbiter (ROM_LAT=1, MAX_WAIT=8).
module tb_font_rom_arbiter;

   localparam int unsigned ADDR_SIZE = 7;
   localparam int unsigned FNT_W     = 4;

   logic                 clk = 1'b0;
   logic                 rst;
   logic [ADDR_SIZE-1:0] rom_addr;
   logic [FNT_W-1:0]     rom_q;
   logic                 a_req, b_req;
   logic [ADDR_SIZE-1:0] a_addr, b_addr;
   logic                 a_gnt, b_gnt, a_valid, b_valid;
   logic [FNT_W-1:0]     a_data, b_data;

   int n_chk  = 0;
   int n_fail = 0;

   font_rom_arbiter #(
      .ADDR_SIZE(ADDR_SIZE), .FNT_W(FNT_W), .ROM_LAT(1), .MAX_WAIT(8)
   ) dut (
      .clk(clk), .rst(rst), .rom_addr(rom_addr), .rom_q(rom_q),
      .a_req(a_req), .a_addr(a_addr), .a_gnt(a_gnt), .a_valid(a_valid), .a_data(a_data),
      .b_req(b_req), .b_addr(b_addr), .b_gnt(b_gnt), .b_valid(b_valid), .b_data(b_data)
   );

   always #5 clk = ~clk;

   function automatic logic [FNT_W-1:0] rom_fn(input logic [ADDR_SIZE-1:0] a);
      return a[3:0] ^ 4'h9;
   endfunction

   // One-cycle-latency synchronous ROM model
   always @(posedge clk) rom_q <= rom_fn(rom_addr);

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Drive one cycle's inputs just after the edge, then move to the sampling point
   task automatic cyc(input logic r, input logic ar, input logic [ADDR_SIZE-1:0] aa,
                      input logic br, input logic [ADDR_SIZE-1:0] ba);
      @(posedge clk);
      #1;
      rst = r; a_req = ar; a_addr = aa; b_req = br; b_addr = ba;
      @(negedge clk);
   endtask

   initial begin
      rst = 1'b1; a_req = 1'b1; b_req = 1'b1; a_addr = 7'h23; b_addr = 7'h55;

      // Reset held with both requesting
      cyc(1'b1, 1'b1, 7'h23, 1'b1, 7'h55);
      cyc(1'b1, 1'b1, 7'h23, 1'b1, 7'h55);
      chk("rst_a_gnt", a_gnt, 0);
      chk("rst_b_gnt", b_gnt, 0);
      chk("rst_rom_addr", rom_addr, 0);
      chk("rst_a_valid", a_valid, 0);
      chk("rst_b_valid", b_valid, 0);
      chk("rst_a_data", a_data, 0);

      // Release: A granted in the first cycle, single read of 0x23
      cyc(1'b0, 1'b1, 7'h23, 1'b1, 7'h55);
      chk("rel_a_gnt", a_gnt, 1);
      chk("rel_b_gnt", b_gnt, 0);
      cyc(1'b0, 1'b0, 7'h00, 1'b0, 7'h00);
      chk("single_rom_addr", rom_addr, 7'h23);
      chk("single_k1_valid", a_valid, 0);
      cyc(1'b0, 1'b0, 7'h00, 1'b0, 7'h00);
      chk("single_k2_valid", a_valid, 0);
      cyc(1'b0, 1'b0, 7'h00, 1'b0, 7'h00);
      chk("single_k3_valid", a_valid, 1);
      chk("single_k3_data", a_data, 4'hA);
      chk("single_k3_bvalid", b_valid, 0);
      cyc(1'b0, 1'b0, 7'h00, 1'b0, 7'h00);
      chk("single_k4_valid", a_valid, 0);
      chk("single_k4_hold", a_data, 4'hA);

      // Pipelined A, B, A
      cyc(1'b0, 1'b1, 7'h01, 1'b0, 7'h00);
      chk("pipe_gnt0", {a_gnt, b_gnt}, 2'b10);
      cyc(1'b0, 1'b0, 7'h00, 1'b1, 7'h02);
      chk("pipe_gnt1", {a_gnt, b_gnt}, 2'b01);
      cyc(1'b0, 1'b1, 7'h03, 1'b0, 7'h00);
      chk("pipe_gnt2", {a_gnt, b_gnt}, 2'b10);
      cyc(1'b0, 1'b0, 7'h00, 1'b0, 7'h00);
      chk("pipe_v0", {a_valid, b_valid}, 2'b10);
      chk("pipe_d0", a_data, 4'h8);
      cyc(1'b0, 1'b0, 7'h00, 1'b0, 7'h00);
      chk("pipe_v1", {a_valid, b_valid}, 2'b01);
      chk("pipe_d1", b_data, 4'hB);
      chk("pipe_d1_ahold", a_data, 4'h8);
      cyc(1'b0, 1'b0, 7'h00, 1'b0, 7'h00);
      chk("pipe_v2", {a_valid, b_valid}, 2'b10);
      chk("pipe_d2", a_data, 4'hA);
      chk("pipe_d2_bhold", b_data, 4'hB);
      cyc(1'b0, 1'b0, 7'h00, 1'b0, 7'h00);
      chk("pipe_v3", {a_valid, b_valid}, 2'b00);

      // Starvation guard: B every 9th cycle under contention
      for (int i = 1; i <= 40; i++) begin
         cyc(1'b0, 1'b1, 7'h10, 1'b1, 7'h20);
         chk($sformatf("starve_a_gnt_%0d", i), a_gnt, (i % 9 == 0) ? 0 : 1);
         chk($sformatf("starve_b_gnt_%0d", i), b_gnt, (i % 9 == 0) ? 1 : 0);
      end

      // Contention release: B wins as soon as A drops, then its wait restarts from zero
      cyc(1'b0, 1'b0, 7'h00, 1'b0, 7'h00);
      for (int i = 1; i <= 3; i++) begin
         cyc(1'b0, 1'b1, 7'h11, 1'b1, 7'h22);
         chk($sformatf("cont_a_%0d", i), {a_gnt, b_gnt}, 2'b10);
      end
      cyc(1'b0, 1'b0, 7'h00, 1'b1, 7'h22);
      chk("cont_release", {a_gnt, b_gnt}, 2'b01);
      for (int i = 1; i <= 9; i++) begin
         cyc(1'b0, 1'b1, 7'h11, 1'b1, 7'h33);
         chk($sformatf("cont_after_%0d", i), {a_gnt, b_gnt}, (i == 9) ? 2'b01 : 2'b10);
      end
      cyc(1'b0, 1'b1, 7'h11, 1'b0, 7'h00);
      chk("breq_low_a", {a_gnt, b_gnt}, 2'b10);
      for (int i = 0; i < 4; i++) cyc(1'b0, 1'b0, 7'h00, 1'b0, 7'h00);
      chk("pre_flight_bdata", b_data, 4'hA);

      // Reset mid-flight drops the outstanding B read
      cyc(1'b0, 1'b0, 7'h00, 1'b1, 7'h35);
      chk("flight_b_gnt", b_gnt, 1);
      cyc(1'b1, 1'b1, 7'h12, 1'b1, 7'h36);
      chk("flight_rst_gnt", {a_gnt, b_gnt}, 2'b00);
      chk("flight_rst_addr", rom_addr, 0);
      chk("flight_rst_bdata", b_data, 0);
      for (int i = 1; i <= 5; i++) begin
         cyc(1'b0, 1'b0, 7'h00, 1'b0, 7'h00);
         chk($sformatf("flight_bvalid_%0d", i), b_valid, 0);
         chk($sformatf("flight_bdata_%0d", i), b_data, 0);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
